// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream interface for fir_coeff_loader.
// Carries one signed coefficient word per valid/ready handshake.
//   s_coeff_data  : signed coefficient word, index order 0..N_TAPS
//   s_coeff_valid : producer has a word on s_coeff_data
//   s_coeff_ready : loader accepts the word this cycle
// master modport = coefficient producer, slave modport = loader.
interface fir_coeff_loader_if #(
    parameter int COEFF_WIDTH = 16
);
    logic signed [COEFF_WIDTH-1:0] s_coeff_data;
    logic                          s_coeff_valid;
    logic                          s_coeff_ready;

    modport master (
        output s_coeff_data,
        output s_coeff_valid,
        input  s_coeff_ready
    );

    modport slave (
        input  s_coeff_data,
        input  s_coeff_valid,
        output s_coeff_ready
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader.
// Collects N_TAPS+1 signed coefficient words from a valid/ready stream into a
// shadow bank, then copies the whole shadow bank into the active bank in one
// edge and pulses coeff_valid for one cycle. A partial, timed-out, reset or
// cleared load never touches the active bank.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   clr          : synchronous clear (banks, counters, error flag, FSM)
//   load_start   : pulse, starts a new load when idle
//   s_coeff      : coefficient stream (slave side of fir_coeff_loader_if)
//   coeff_out    : active coefficient bank, indices 0..N_TAPS
//   coeff_valid  : one-cycle pulse when coeff_out holds a freshly committed bank
//   busy         : loader is not idle
//   tap_count    : words accepted in the current/last load
//   load_err     : sticky, last load timed out; cleared by load_start or clr
module fir_coeff_loader #(
    parameter  int COEFF_WIDTH    = 16,
    parameter  int N_TAPS         = 41,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W          = $clog2(N_TAPS + 2)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          load_start,
    fir_coeff_loader_if.slave             s_coeff,
    output logic signed [COEFF_WIDTH-1:0] coeff_out [N_TAPS:0],
    output logic                          coeff_valid,
    output logic                          busy,
    output logic [CNT_W-1:0]              tap_count,
    output logic                          load_err
);

    // Timer only ever holds values up to TIMEOUT_CYCLES-2.
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   tap_count_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic               load_err_reg;
    logic               coeff_valid_reg;

    logic               hs;
    logic               last_beat;
    logic               timeout_hit;

    assign s_coeff.s_coeff_ready = (state_reg == LOAD);
    assign hs        = s_coeff.s_coeff_valid & s_coeff.s_coeff_ready;
    assign last_beat = (tap_count_reg == CNT_W'(N_TAPS));

    // The timeout fires on the idle cycle in which the timer would reach
    // TIMEOUT_CYCLES-1, i.e. after TIMEOUT_CYCLES-1 consecutive idle cycles.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = (state_reg == LOAD) && !hs &&
                (({1'b0, timer_reg} + (TMR_W + 1)'(1)) >= (TMR_W + 1)'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        if (last_beat) begin
                            state_next = COMMIT;
                        end
                    end else if (timeout_hit) begin
                        state_next = IDLE;
                    end
                end
                COMMIT:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // --------------------------------------------- counters, flags, pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_count_reg   <= '0;
            timer_reg       <= '0;
            load_err_reg    <= 1'b0;
            coeff_valid_reg <= 1'b0;
        end else if (clr) begin
            tap_count_reg   <= '0;
            timer_reg       <= '0;
            load_err_reg    <= 1'b0;
            coeff_valid_reg <= 1'b0;
        end else begin
            // The pulse coincides with the edge that copies shadow into active.
            coeff_valid_reg <= (state_reg == COMMIT);
            case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        tap_count_reg <= '0;
                        timer_reg     <= '0;
                        load_err_reg  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        tap_count_reg <= tap_count_reg + CNT_W'(1);
                        timer_reg     <= '0;
                    end else if (timeout_hit) begin
                        // tap_count is left showing how far the load got.
                        load_err_reg  <= 1'b1;
                    end else begin
                        timer_reg     <= timer_reg + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // --------------------------------------------- shadow and active banks
    // Each word has its own write decode so the shadow never needs an
    // out-of-range index, and the commit copies every word in the same edge.
    generate
        for (genvar gi = 0; gi <= N_TAPS; gi++) begin : g_bank
            logic signed [COEFF_WIDTH-1:0] shadow_word_reg;
            logic signed [COEFF_WIDTH-1:0] active_word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_word_reg <= '0;
                end else if (clr) begin
                    shadow_word_reg <= '0;
                end else if (hs && (tap_count_reg == CNT_W'(gi))) begin
                    shadow_word_reg <= s_coeff.s_coeff_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    active_word_reg <= '0;
                end else if (clr) begin
                    active_word_reg <= '0;
                end else if (state_reg == COMMIT) begin
                    active_word_reg <= shadow_word_reg;
                end
            end

            assign coeff_out[gi] = active_word_reg;
        end
    endgenerate

    assign coeff_valid = coeff_valid_reg;
    assign busy        = (state_reg != IDLE);
    assign tap_count   = tap_count_reg;
    assign load_err    = load_err_reg;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard testbench for fir_coeff_loader.
// Two loaders share clock, reset and clr: dut_a uses the default 1024-cycle
// timeout, dut_b a 16-cycle timeout for the timeout scenario. "sel" routes
// stimulus to one of them and muxes its outputs to the monitor.
module tb_fir_coeff_loader;
    localparam int W  = 16;
    localparam int NT = 41;
    localparam int NW = NT + 1;

    typedef logic [W-1:0] word_t;
    typedef word_t [NT:0] bank_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic sel = 1'b0;
    logic drv_start = 1'b0;
    logic drv_valid = 1'b0;
    logic signed [W-1:0] drv_data = '0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fir_coeff_loader_if #(.COEFF_WIDTH(W)) ifc_a ();
    fir_coeff_loader_if #(.COEFF_WIDTH(W)) ifc_b ();

    assign ifc_a.s_coeff_data  = drv_data;
    assign ifc_a.s_coeff_valid = drv_valid & ~sel;
    assign ifc_b.s_coeff_data  = drv_data;
    assign ifc_b.s_coeff_valid = drv_valid & sel;

    logic start_a, start_b;
    assign start_a = drv_start & ~sel;
    assign start_b = drv_start & sel;

    logic signed [W-1:0] out_a [NT:0];
    logic signed [W-1:0] out_b [NT:0];
    logic cv_a, cv_b, busy_a, busy_b, err_a, err_b;
    logic [5:0] tap_a, tap_b;

    fir_coeff_loader #(.COEFF_WIDTH(W), .N_TAPS(NT), .TIMEOUT_CYCLES(1024)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load_start(start_a), .s_coeff(ifc_a),
        .coeff_out(out_a), .coeff_valid(cv_a), .busy(busy_a), .tap_count(tap_a),
        .load_err(err_a)
    );

    fir_coeff_loader #(.COEFF_WIDTH(W), .N_TAPS(NT), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load_start(start_b), .s_coeff(ifc_b),
        .coeff_out(out_b), .coeff_valid(cv_b), .busy(busy_b), .tap_count(tap_b),
        .load_err(err_b)
    );

    logic cv_m, busy_m, err_m, ready_m;
    logic [5:0] tap_m;
    assign cv_m    = sel ? cv_b : cv_a;
    assign busy_m  = sel ? busy_b : busy_a;
    assign err_m   = sel ? err_b : err_a;
    assign ready_m = sel ? ifc_b.s_coeff_ready : ifc_a.s_coeff_ready;
    assign tap_m   = sel ? tap_b : tap_a;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int pulse_cnt = 0;
    int last_hs_cyc = 0;
    bank_t exp_q[$];
    bank_t zero_bank = '0;

    function automatic bank_t cur_bank();
        bank_t r;
        for (int k = 0; k < NW; k++) r[k] = sel ? out_b[k] : out_a[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bank(input string name, input bank_t exp);
        bank_t got;
        int bad;
        got = cur_bank();
        bad = -1;
        checks++;
        for (int k = 0; k < NW; k++) begin
            if (got[k] !== exp[k] && bad < 0) bad = k;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: word %0d got %0d expected %0d", name, bad,
                     $signed(got[bad]), $signed(exp[bad]));
        end
    endtask

    // Monitor: every coeff_valid pulse pops one expected bank.
    initial begin
        bit prev_cv;
        bank_t e;
        prev_cv = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_m) ready_cnt++;
            if ((cv_a && sel) || (cv_b && !sel)) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse: unselected loader coeff_valid=1 expected 0");
            end
            if (prev_cv) chk("pulse_width", cv_m, 0);
            if (cv_m) begin
                pulse_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: coeff_valid=1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk_bank("commit_bank", e);
                    // Beat presented from edge H-1, sampled at H; pulse visible after H+1.
                    chk("commit_latency", cyc - last_hs_cyc, 1);
                    $display("commit: cycle %0d word0=%0d word41=%0d", cyc,
                             $signed(e[0]), $signed(e[NT]));
                end
            end
            prev_cv = cv_m;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        drv_start = 1'b1;
        tick();
        drv_start = 1'b0;
    endtask

    task automatic send_word(input word_t d, input int gap);
        bit ok;
        if (gap > 0) begin
            drv_valid = 1'b0;
            repeat (gap) tick();
        end
        drv_data  = d;
        drv_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (ready_m) begin
                last_hs_cyc = cyc + 1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_wait: ready=0 expected 1");
        end else begin
            tick();
        end
    endtask

    task automatic send_bank(input bank_t b, input int n, input bit gaps, input bit step_chk);
        for (int k = 0; k < n; k++) begin
            send_word(b[k], gaps ? (k * 13) % 21 : 0);
            if (step_chk) begin
                chk("tap_step", tap_m, k + 1);
                chk("busy_in_load", busy_m, 1);
            end
        end
        drv_valid = 1'b0;
    endtask

    initial begin
        bank_t ramp, ext, alt2;
        int hs, seen;
        for (int k = 0; k < NW; k++) begin
            ramp[k] = W'(k * 3 - 60);
            ext[k]  = (k % 2 == 1) ? 16'h7FFF : 16'h8000;
            alt2[k] = W'(1000 - k * 25);
        end

        // Reset state
        repeat (3) tick();
        chk("rst_ready", ready_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_tap", tap_m, 0);
        chk("rst_err", err_m, 0);
        chk("rst_cv", cv_m, 0);
        chk_bank("rst_bank", zero_bank);
        rst_n = 1'b1;
        tick();

        // T1: reset in the middle of a load
        start_load();
        send_bank(ramp, 5, 1'b0, 1'b0);
        chk("t1_tap_before", tap_m, 5);
        rst_n = 1'b0;
        #2;
        chk("t1_busy", busy_m, 0);
        chk("t1_tap", tap_m, 0);
        chk("t1_ready", ready_m, 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t1_busy_after", busy_m, 0);
        chk_bank("t1_bank", zero_bank);
        chk("t1_no_pulse", pulse_cnt, 0);

        // T2: full load, valid held high
        ready_cnt = 0;
        exp_q.push_back(ramp);
        start_load();
        send_bank(ramp, NW, 1'b0, 1'b0);
        repeat (4) tick();
        chk("t2_ready_cycles", ready_cnt, 42);
        chk("t2_pulses", pulse_cnt, 1);
        chk("t2_tap", tap_m, 42);
        chk("t2_busy", busy_m, 0);
        chk_bank("t2_bank_hold", ramp);

        // T3: gaps of 0..20 idle cycles between beats
        exp_q.push_back(ramp);
        start_load();
        chk("t3_tap_start", tap_m, 0);
        chk("t3_busy_start", busy_m, 1);
        send_bank(ramp, NW, 1'b1, 1'b1);
        tick();
        chk("t3_busy_after_commit", busy_m, 0);
        repeat (3) tick();
        chk("t3_pulses", pulse_cnt, 2);

        // T4: timeout on the 16-cycle loader
        sel = 1'b1;
        exp_q.push_back(alt2);
        start_load();
        send_bank(alt2, NW, 1'b0, 1'b0);
        repeat (3) tick();
        chk("t4_first_pulse", pulse_cnt, 3);
        start_load();
        send_bank(alt2, 10, 1'b0, 1'b0);
        hs = last_hs_cyc;
        seen = -1;
        for (int t = 0; t < 40 && seen < 0; t++) begin
            @(negedge clk);
            if (err_m) seen = cyc;
        end
        chk("t4_timeout_cycles", seen - hs, 15);
        tick();
        chk("t4_err", err_m, 1);
        chk("t4_busy", busy_m, 0);
        chk("t4_tap_hold", tap_m, 10);
        chk_bank("t4_bank_kept", alt2);
        chk("t4_no_pulse", pulse_cnt, 3);
        start_load();
        chk("t4_err_cleared", err_m, 0);
        chk("t4_tap_restart", tap_m, 0);
        chk("t4_busy_restart", busy_m, 1);
        sel = 1'b0;

        // T5: clr priority
        clr = 1'b1;
        drv_start = 1'b1;
        tick();
        clr = 1'b0;
        drv_start = 1'b0;
        chk("t5_busy", busy_m, 0);
        chk("t5_tap", tap_m, 0);
        chk("t5_err", err_m, 0);
        chk_bank("t5_bank_zero", zero_bank);
        start_load();
        send_bank(ramp, 20, 1'b0, 1'b0);
        chk("t5_tap_20", tap_m, 20);
        drv_data  = ramp[20];
        drv_valid = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drv_valid = 1'b0;
        chk("t5_busy_clr", busy_m, 0);
        chk("t5_tap_clr", tap_m, 0);
        chk("t5_ready_clr", ready_m, 0);
        chk_bank("t5_bank_clr", zero_bank);
        repeat (5) tick();
        chk("t5_no_pulse", pulse_cnt, 3);

        // T6: extreme values and load_start on the coeff_valid cycle
        exp_q.push_back(ext);
        start_load();
        send_bank(ext, NW, 1'b0, 1'b0);
        tick();
        chk("t6_cv_high", cv_m, 1);
        exp_q.push_back(alt2);
        start_load();
        chk("t6_busy", busy_m, 1);
        chk("t6_tap", tap_m, 0);
        chk("t6_ready", ready_m, 1);
        send_bank(alt2, NW, 1'b0, 1'b0);
        repeat (4) tick();
        chk("t6_pulses", pulse_cnt, 5);
        chk_bank("t6_final_bank", alt2);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
